cacheline_adaptor: RTL and testbench



---
 rtl/cacheline_adaptor_if.sv | 42 ++++
 rtl/cacheline_adaptor.sv | 124 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// rtl/cacheline_adaptor_if.sv - cache-side and memory-side signal bundle for cacheline_adaptor
//
// Purpose: groups the cache line request/response signals and the
// memory burst signals of the adaptor into one interface.
//
// Ports (named from the adaptor's point of view):
//   read_i, write_i, address_i, line_i : line request from the cache
//   line_o, resp_o                     : assembled read line, completion pulse
//   address_o, read_o, write_o         : burst request toward memory
//   burst_o, burst_i, resp_i           : write beat, read beat, beat handshake
//
// Modports:
//   slave  : the adaptor
//   master : the environment (cache plus memory) driving the adaptor
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic               read_i;
  logic               write_i;
  logic [ADDR_W-1:0]  address_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cache line to multi-beat memory burst adaptor
//
// Purpose: services a full-line read or write from the cache as a
// BEATS-beat burst toward main memory. Read beats are assembled into
// line_o, write lines are split into beats on burst_o, and a single-cycle
// resp_o is returned after the last beat.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : cacheline_adaptor_if.slave (cache request/response and
//              memory burst signals, see rtl/cacheline_adaptor_if.sv)
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  cacheline_adaptor_if.slave   bus
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  line_q;
  logic [LINE_W-1:0]  line_o_q;
  logic               read_q;
  logic               write_q;
  logic               resp_q;
  logic [BURST_W-1:0] burst_q;

  assign cnt_nxt = cnt + 1'b1;

  // Every output comes straight from a register, so resp_i never reaches
  // an output combinationally.
  assign bus.address_o = addr_q;
  assign bus.line_o    = line_o_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = burst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      line_o_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      resp_q   <= 1'b0;
      burst_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Write wins when both requests are raised.
          if (bus.write_i) begin
            addr_q  <= {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            line_q  <= bus.line_i;
            cnt     <= '0;
            burst_q <= bus.line_i[BURST_W-1:0];
            write_q <= 1'b1;
            state   <= WR_BURST;
          end else if (bus.read_i) begin
            addr_q <= {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt    <= '0;
            read_q <= 1'b1;
            state  <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (bus.resp_i) begin
            line_o_q[int'(cnt)*BURST_W +: BURST_W] <= bus.burst_i;
            if (cnt == LAST) begin
              read_q <= 1'b0;
              resp_q <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end

        WR_BURST: begin
          if (bus.resp_i) begin
            if (cnt == LAST) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state   <= DONE;
            end else begin
              // Present the next beat in the cycle right after acceptance.
              cnt     <= cnt_nxt;
              burst_q <= line_q[int'(cnt_nxt)*BURST_W +: BURST_W];
            end
          end
        end

        DONE: begin
          // Requests still high here belong to the finished transaction.
          resp_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
//
// Purpose: drives the cache and memory sides of the adaptor through
// directed and randomized line reads and writes, and compares against a
// line-level model of memory beats kept in the bench.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int resp_count = 0;

  logic [255:0] exp_line;
  logic [63:0]  rd_beats [4];

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of cycles resp_o was high, sampled before each edge updates it.
  always @(posedge clk) begin
    if (bus.resp_o === 1'b1) resp_count <= resp_count + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input int cyc, input bit [15:0] pat, input int plen, input bit rnd);
    if (cyc < plen) return pat[cyc];
    if (rnd && cyc < 40) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return (a / 32) * 32;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends on a negedge; ends in the IDLE cycle after DONE with
  // the request dropped, so a following task starts with no idle gap.
  task automatic do_read(input logic [31:0] addr, input bit [15:0] pat, input int plen,
                         input bit rnd, input int exp_lat);
    int n;
    int cyc;
    bit r;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.address_i = addr;
    step();
    bus.address_i = $urandom;
    n = 0;
    cyc = 0;
    while (n < 4) begin
      check("rd_read_o", bus.read_o, 1'b1);
      check("rd_write_o", bus.write_o, 1'b0);
      check("rd_resp_o_busy", bus.resp_o, 1'b0);
      check("rd_address_o", bus.address_o, line_base(addr));
      r = pick(cyc, pat, plen, rnd);
      bus.resp_i  = r;
      bus.burst_i = r ? rd_beats[n] : {$urandom, $urandom};
      step();
      if (r) n++;
      cyc++;
    end
    exp_line = '0;
    for (int i = 0; i < 4; i++) exp_line = exp_line | ({192'b0, rd_beats[i]} << (64 * i));
    bus.resp_i  = 1'b1;
    bus.burst_i = {$urandom, $urandom};
    check("rd_resp_o_done", bus.resp_o, 1'b1);
    check("rd_read_o_done", bus.read_o, 1'b0);
    check("rd_write_o_done", bus.write_o, 1'b0);
    check("rd_line_o", bus.line_o, exp_line);
    if (exp_lat > 0) check("rd_latency", cyc + 1, exp_lat);
    step();
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    check("rd_resp_o_after", bus.resp_o, 1'b0);
    check("rd_read_o_after", bus.read_o, 1'b0);
    check("rd_line_o_after", bus.line_o, exp_line);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit also_read,
                          input bit [15:0] pat, input int plen, input bit rnd);
    int n;
    int cyc;
    bit r;
    logic [255:0] sh;
    bus.write_i   = 1'b1;
    bus.read_i    = also_read;
    bus.address_i = addr;
    bus.line_i    = line;
    step();
    bus.line_i    = {8{$urandom}};
    bus.address_i = $urandom;
    n = 0;
    cyc = 0;
    while (n < 4) begin
      sh = line >> (64 * n);
      check("wr_write_o", bus.write_o, 1'b1);
      check("wr_read_o", bus.read_o, 1'b0);
      check("wr_resp_o_busy", bus.resp_o, 1'b0);
      check("wr_address_o", bus.address_o, line_base(addr));
      check("wr_burst_o", bus.burst_o, sh[63:0]);
      r = pick(cyc, pat, plen, rnd);
      bus.resp_i  = r;
      bus.burst_i = {$urandom, $urandom};
      step();
      if (r) n++;
      cyc++;
    end
    bus.resp_i = 1'b1;
    check("wr_resp_o_done", bus.resp_o, 1'b1);
    check("wr_write_o_done", bus.write_o, 1'b0);
    check("wr_read_o_done", bus.read_o, 1'b0);
    check("wr_line_o_kept", bus.line_o, exp_line);
    step();
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    bus.resp_i  = 1'b0;
    check("wr_resp_o_after", bus.resp_o, 1'b0);
    check("wr_write_o_after", bus.write_o, 1'b0);
  endtask

  initial begin
    int snap;
    logic [255:0] wline;
    rst           = 1'b1;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    exp_line      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_o", bus.read_o, 1'b0);
    check("rst_write_o", bus.write_o, 1'b0);
    check("rst_resp_o", bus.resp_o, 1'b0);
    check("rst_line_o", bus.line_o, '0);
    check("rst_burst_o", bus.burst_o, '0);
    check("rst_address_o", bus.address_o, '0);
    rst = 1'b0;
    step();

    // Read, no stalls.
    rd_beats[0] = {16{4'h1}};
    rd_beats[1] = {16{4'h2}};
    rd_beats[2] = {16{4'h3}};
    rd_beats[3] = {16{4'h4}};
    do_read(32'h0000_1234, 16'h0, 0, 1'b0, 5);
    step();

    // Read with stall pattern 1,0,0,1,0,1,1; stays idle afterwards.
    do_read(32'h0000_1234, 16'h0069, 7, 1'b0, 8);
    check("held_no_reissue", bus.read_o, 1'b0);
    step();
    check("held_no_reissue2", bus.read_o, 1'b0);

    // Write, then fill with no idle cycle in between.
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    snap = resp_count;
    do_write(32'h0000_8040, wline, 1'b0, 16'h0005, 4, 1'b0);
    rd_beats[0] = 64'h0123_4567_89AB_CDEF;
    rd_beats[1] = 64'hFEDC_BA98_7654_3210;
    rd_beats[2] = 64'hDEAD_BEEF_0000_0001;
    rd_beats[3] = 64'h8000_0000_CAFE_F00D;
    do_read(32'h0000_8040, 16'h0, 0, 1'b0, 5);
    check("wb_fill_resp_pulses", resp_count - snap, 2);
    step();

    // Both requests high: the write is serviced.
    do_write(32'hABCD_EF1F, {8{$urandom}}, 1'b1, 16'h0, 0, 1'b1);
    step();

    // Reset after two read beats.
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_2000;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      step();
    end
    rst        = 1'b1;
    bus.resp_i = 1'b0;
    step();
    exp_line = '0;
    check("mid_rst_read_o", bus.read_o, 1'b0);
    check("mid_rst_resp_o", bus.resp_o, 1'b0);
    check("mid_rst_line_o", bus.line_o, '0);
    rst        = 1'b0;
    bus.read_i = 1'b0;
    step();
    for (int i = 0; i < 4; i++) rd_beats[i] = {$urandom, $urandom};
    do_read(32'h0000_2004, 16'h0, 0, 1'b0, 5);
    step();

    // Randomized mix.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, {8{$urandom}}, 1'b0, 16'h0, 0, 1'b1);
      end else begin
        for (int i = 0; i < 4; i++) rd_beats[i] = {$urandom, $urandom};
        do_read($urandom, 16'h0, 0, 1'b1, 0);
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
